// File: rtl/reorder_pkg.sv
// Shared constants and helpers for the reorder buffer and its rename table.
// Ids run 1..ENTRIES; id 0 (NO_TAG) means "no producer" on the CDB and in the tag table.
// No logic of its own; the wrap increment is used for both head and tail pointers.
package reorder_pkg;

  localparam int ENTRIES = 7;
  localparam int ID_W    = 3;
  localparam int REG_W   = 5;

  localparam logic [ID_W-1:0] NO_TAG = '0;

  // Pointer step 1,2,...,ENTRIES,1 (id 0 is reserved and never visited).
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
    return (id == ID_W'(ENTRIES)) ? ID_W'(1) : id + ID_W'(1);
  endfunction

endpackage

// File: rtl/reorder_buf_if.sv
// Issue/CDB/lookup/commit bus between the reorder buffer and the pipeline around it.
// Pure wiring; lookup and commit outputs are combinational views of buffer state.
// No backpressure on commit; alloc_ready is the only stall signal.
interface reorder_buf_if #(
  parameter int DATA_W = 32
);
  import reorder_pkg::*;

  logic              alloc_valid;
  logic [REG_W-1:0]  alloc_dest;
  logic              alloc_wr;
  logic              alloc_ready;
  logic [ID_W-1:0]   alloc_id;

  logic [ID_W-1:0]   cdb_id;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_int;

  logic [REG_W-1:0]  src_reg;
  logic [ID_W-1:0]   src_tag;
  logic              src_ready;
  logic [DATA_W-1:0] src_data;

  logic              commit_valid;
  logic [ID_W-1:0]   commit_id;
  logic [REG_W-1:0]  commit_dest;
  logic              commit_wr;
  logic [DATA_W-1:0] commit_data;

  // Pipeline side: issues allocations, drives the CDB, asks for operands.
  modport master (
    output alloc_valid, alloc_dest, alloc_wr,
    input  alloc_ready, alloc_id,
    output cdb_id, cdb_data, cdb_int,
    output src_reg,
    input  src_tag, src_ready, src_data,
    input  commit_valid, commit_id, commit_dest, commit_wr, commit_data
  );

  // Reorder buffer side.
  modport slave (
    input  alloc_valid, alloc_dest, alloc_wr,
    output alloc_ready, alloc_id,
    input  cdb_id, cdb_data, cdb_int,
    input  src_reg,
    output src_tag, src_ready, src_data,
    output commit_valid, commit_id, commit_dest, commit_wr, commit_data
  );

endinterface

// File: rtl/reorder_buf_rename_table.sv
// Register -> pending producer id table (register 0 hardwired to NO_TAG).
// Write/clear take effect on the next edge; the read port is combinational.
// No backpressure; an allocation write beats a same-cycle commit clear on the same register.
// Optional clear-all port exists only when REORDER_BUF_FLUSH_EN is defined.
module rename_table
  import reorder_pkg::*;
#(
  parameter int REG_N = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef REORDER_BUF_FLUSH_EN
  input  logic             clr_all,
`endif
  input  logic             wr_en,
  input  logic [REG_W-1:0] wr_reg,
  input  logic [ID_W-1:0]  wr_tag,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_reg,
  input  logic [ID_W-1:0]  clr_tag,
  input  logic [REG_W-1:0] rd_reg,
  output logic [ID_W-1:0]  rd_tag
);

  logic [ID_W-1:0] tags [REG_N];

  // Tag updates: newest allocation wins; a commit only clears a tag it still owns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < REG_N; r++) tags[r] <= NO_TAG;
    end else begin
      for (int r = 1; r < REG_N; r++) begin
`ifdef REORDER_BUF_FLUSH_EN
        if (clr_all) tags[r] <= NO_TAG;
        else
`endif
        if (wr_en && (wr_reg == REG_W'(r))) tags[r] <= wr_tag;
        else if (clr_en && (clr_reg == REG_W'(r)) && (tags[r] == clr_tag)) tags[r] <= NO_TAG;
      end
    end
  end

  assign rd_tag = (rd_reg == '0) ? NO_TAG : tags[rd_reg];

endmodule

// File: rtl/reorder_buf.sv
// 7-entry in-order-retire reorder buffer with register renaming and CDB capture.
// Alloc/CDB results visible one edge later; commit and operand lookup are combinational.
// alloc_ready drops when all entries are in use; commit has no backpressure.
// REORDER_BUF_FLUSH_EN adds a flush input that empties the buffer on the next edge.
module reorder_buf
  import reorder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic         clk,
  input  logic         rst,
`ifdef REORDER_BUF_FLUSH_EN
  input  logic         flush,
`endif
  reorder_buf_if.slave bus
);

  // Entry storage indexed directly by id; slot 0 is never allocated.
  logic              busy     [ENTRIES+1];
  logic              complete [ENTRIES+1];
  logic [REG_W-1:0]  dest     [ENTRIES+1];
  logic              wr       [ENTRIES+1];
  logic [DATA_W-1:0] result   [ENTRIES+1];

  logic [ID_W-1:0] head;
  logic [ID_W-1:0] tail;
  logic [ID_W-1:0] count;

  logic            has_room;
  logic            alloc_fire;
  logic            commit_fire;
  logic            cdb_fire;
  logic            ren_wr_en;
  logic [ID_W-1:0] src_tag;
  logic            cdb_hit;

  // Room is judged on the pre-commit count: a full buffer stalls even if the head retires now.
  assign has_room = (count != ID_W'(ENTRIES));

`ifdef REORDER_BUF_FLUSH_EN
  assign alloc_fire  = bus.alloc_valid && has_room && !flush;
  assign commit_fire = busy[head] && complete[head] && !flush;
`else
  assign alloc_fire  = bus.alloc_valid && has_room;
  assign commit_fire = busy[head] && complete[head];
`endif

  // Late or duplicate broadcasts (idle, free entry, already complete) are dropped.
  assign cdb_fire = (bus.cdb_id != NO_TAG) && busy[bus.cdb_id] && !complete[bus.cdb_id];

  // Entry state: commit frees the head, CDB completes a producer, allocation claims the tail.
  // These never collide: the tail is free when allocating and the head is already complete.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= ENTRIES; i++) begin
        busy[i]     <= 1'b0;
        complete[i] <= 1'b0;
        dest[i]     <= '0;
        wr[i]       <= 1'b0;
        result[i]   <= '0;
      end
    end
`ifdef REORDER_BUF_FLUSH_EN
    else if (flush) begin
      for (int i = 0; i <= ENTRIES; i++) begin
        busy[i]     <= 1'b0;
        complete[i] <= 1'b0;
      end
    end
`endif
    else begin
      if (commit_fire) begin
        busy[head]     <= 1'b0;
        complete[head] <= 1'b0;
      end
      if (cdb_fire) begin
        complete[bus.cdb_id] <= 1'b1;
        result[bus.cdb_id]   <= bus.cdb_data;
        if (bus.cdb_int) wr[bus.cdb_id] <= 1'b0;
      end
      if (alloc_fire) begin
        busy[tail]     <= 1'b1;
        complete[tail] <= 1'b0;
        dest[tail]     <= bus.alloc_dest;
        wr[tail]       <= bus.alloc_wr;
      end
    end
  end

  // Head/tail pointers and occupancy; simultaneous alloc+commit leaves count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= ID_W'(1);
      tail  <= ID_W'(1);
      count <= '0;
    end
`ifdef REORDER_BUF_FLUSH_EN
    else if (flush) begin
      head  <= tail;
      count <= '0;
    end
`endif
    else begin
      if (alloc_fire)  tail <= wrap_inc(tail);
      if (commit_fire) head <= wrap_inc(head);
      if (alloc_fire && !commit_fire)      count <= count + ID_W'(1);
      else if (!alloc_fire && commit_fire) count <= count - ID_W'(1);
    end
  end

  assign ren_wr_en = alloc_fire && bus.alloc_wr && (bus.alloc_dest != '0);

  rename_table #(
    .REG_N (REG_N)
  ) u_rename (
    .clk     (clk),
    .rst     (rst),
`ifdef REORDER_BUF_FLUSH_EN
    .clr_all (flush),
`endif
    .wr_en   (ren_wr_en),
    .wr_reg  (bus.alloc_dest),
    .wr_tag  (tail),
    .clr_en  (commit_fire),
    .clr_reg (dest[head]),
    .clr_tag (head),
    .rd_reg  (bus.src_reg),
    .rd_tag  (src_tag)
  );

  assign bus.alloc_ready  = has_room;
  assign bus.alloc_id     = tail;

  assign bus.commit_valid = commit_fire;
  assign bus.commit_id    = head;
  assign bus.commit_dest  = dest[head];
  assign bus.commit_wr    = wr[head];
  assign bus.commit_data  = result[head];

  // Operand lookup with a bypass from the result broadcast in this same cycle.
  assign cdb_hit       = (src_tag != NO_TAG) && (bus.cdb_id == src_tag);
  assign bus.src_tag   = src_tag;
  assign bus.src_ready = (src_tag == NO_TAG) || complete[src_tag] || cdb_hit;
  assign bus.src_data  = complete[src_tag] ? result[src_tag] : bus.cdb_data;

endmodule

// File: doc/reorder_buf.md
REORDER_BUF -- requirements
Module: reorder_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, result/data width.
REQ-002 SHALL have parameter REG_N, default 32, architectural register count; register 0 is never renamed.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have the issue-side allocation ports:
- alloc_valid, input, 1, allocation request.
- alloc_dest, input, 5, destination register.
- alloc_wr, input, 1, the entry writes a register; 0 for internal-only ops.
- alloc_ready, output, 1, a free entry exists.
- alloc_id, output, 3, id the entry will receive.
REQ-006 SHALL have the CDB ports:
- cdb_id, input, 3, producer id; 0 = bus idle.
- cdb_data, input, DATA_W, result.
- cdb_int, input, 1, internal result with no register write.
REQ-007 SHALL have the operand lookup ports:
- src_reg, input, 5, register queried.
- src_tag, output, 3, pending producer id; 0 = architectural.
- src_ready, output, 1, value available.
- src_data, output, DATA_W, value when tag nonzero and ready.
REQ-008 SHALL have the commit ports:
- commit_valid, output, 1, head retires this cycle.
- commit_id, output, 3, retiring id.
- commit_dest, output, 5, destination register.
- commit_wr, output, 1, register write enable.
- commit_data, output, DATA_W, value written.

Function
REQ-009 SHALL hold 7 entries with ids 1..7; each entry has busy, complete, dest, wr and result fields; head and tail pointers step 1,2,...,7,1.
REQ-010 SHALL drive alloc_ready = (count < 7) and alloc_id = tail; count is the value before any same-cycle commit, with no full-queue bypass.
REQ-011 SHALL on alloc_valid && alloc_ready set entry[tail] busy=1, complete=0, latch dest/wr, and advance tail.
REQ-012 SHALL set rename[alloc_dest] = tail on an accepted allocation with alloc_wr=1 and alloc_dest != 0.
REQ-013 SHALL on cdb_id != 0 with entry[cdb_id] busy latch cdb_data into result and set complete=1 on the next edge.
REQ-014 SHALL ignore a CDB write to a non-busy entry or an already-complete entry.
REQ-015 SHALL on cdb_int=1 mark the entry complete and force its commit_wr to 0.
REQ-016 SHALL drive commit_valid combinationally = entry[head] busy && complete, with no backpressure.
REQ-017 SHALL on commit clear busy, advance head, decrement count, and clear rename[dest] to 0 only if it still equals head.
REQ-018 SHALL resolve a same-cycle allocation rename write and commit rename clear on the same register in favour of the allocation.
REQ-019 SHALL allow allocation and commit in the same cycle, leaving count unchanged.
REQ-020 SHALL compute the lookup combinationally: src_tag = rename[src_reg]; src_ready = 1 when the tag is 0, or entry[tag] is complete, or cdb_id == tag (CDB bypass, src_data = cdb_data).
REQ-021 SHALL return tag 0 and ready 1 for src_reg = 0.

Reset
REQ-022 SHALL while rst=0 asynchronously clear all busy/complete flags and all rename entries, set head=tail=1 and count=0; outputs then read alloc_ready=1, alloc_id=1, commit_valid=0.
REQ-023 SHALL on reset mid-operation discard all in-flight entries without committing them.

Configuration
REQ-024 SHALL when REORDER_BUF_FLUSH_EN is defined add input flush (1 bit); flush=1 clears all entries and the rename table on the next edge, sets head=tail and count=0, suppresses commit_valid that cycle, and overrides same-cycle allocation and CDB writes.
REQ-025 SHALL without REORDER_BUF_FLUSH_EN have no flush port and no flush logic.

Structure
REQ-026 SHALL place ENTRIES=7, ID_W=3, NO_TAG=0 and the wrap-increment function in shared package reorder_pkg.
REQ-027 SHALL implement the 31-entry tag table as sub-module rename_table, with one write port for allocation, one clear port for commit, and one combinational read port.

Verification
REQ-028 SHALL cover reset then alloc r5 -> alloc_id=1, src_reg=5 gives tag 1 ready 0; cdb_id=1 data 0xDEAD -> next cycle commit_valid=1, commit_dest=5, data 0xDEAD, then tag 0.
REQ-029 SHALL cover 7 allocations with no CDB -> alloc_ready=0; an 8th request is ignored; complete id 1 -> commit -> alloc_ready=1, alloc_id=1 (wrap).
REQ-030 SHALL cover out-of-order completion: ids 1,2,3 allocated, CDB order 3,2,1 -> commits in order 1,2,3 on consecutive cycles.
REQ-031 SHALL cover two allocations to r7 (ids 1,2), commit id 1 -> rename[7] stays 2; the same-cycle CDB bypass for id 2 gives src_ready=1 and src_data = cdb_data.
REQ-032 SHALL cover cdb_int on id 1 -> commit_valid=1 with commit_wr=0; rst low mid-queue -> count 0 and no commits.
REQ-033 SHALL cover, with REORDER_BUF_FLUSH_EN defined, flush with 4 entries busy -> next cycle alloc_ready=1, commit_valid=0, all tags 0.
